mips_hazard_ctrl: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage MIPS pipeline; successor to the fixed hazard unit.

---
 rtl/mips_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: operand forwarding,
// load/branch interlocks, memory-ready stalls, multi-cycle mul/div hold in E and a stall counter.
//
// state | meaning
// IDLE  | no mul/div held in E; a new mul/div stalls on its first cycle in E
// BUSY  | mul/div held in E; md_cnt counts the remaining stall cycles down to 0
module mips_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             PCSrcD,
    input  logic             MulDivE,
    input  logic             MemAccessM,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MD_W = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'((MULDIV_LAT > 2) ? (MULDIV_LAT - 2) : 0);
    localparam logic MD_MULTI = (MULDIV_LAT > 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    mdState_t        mdState;
    logic [MD_W-1:0] md_cnt;

    logic lwstall;
    logic brstall;
    logic dstall;
    logic mdstall;
    logic srcHitE;
    logic srcHitM;

    // Register zero is hardwired, so it never creates a dependency.
    function automatic logic regHit(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_comb begin
        ForwardAD = RegWriteM && regHit(WriteRegM, RsD);
        ForwardBD = RegWriteM && regHit(WriteRegM, RtD);

        if (RegWriteM && regHit(WriteRegM, RsE))
            ForwardAE = 2'b10;
        else if (RegWriteW && regHit(WriteRegW, RsE))
            ForwardAE = 2'b01;
        else
            ForwardAE = 2'b00;

        if (RegWriteM && regHit(WriteRegM, RtE))
            ForwardBE = 2'b10;
        else if (RegWriteW && regHit(WriteRegW, RtE))
            ForwardBE = 2'b01;
        else
            ForwardBE = 2'b00;
    end

    assign srcHitE = regHit(WriteRegE, RsD) || regHit(WriteRegE, RtD);
    assign srcHitM = regHit(WriteRegM, RsD) || regHit(WriteRegM, RtD);

    assign lwstall = MemtoRegE && (regHit(RtE, RsD) || regHit(RtE, RtD));
    assign brstall = BranchD && ((RegWriteE && srcHitE) || (MemtoRegM && srcHitM));
    assign dstall  = MemAccessM && !dmem_ready;
    assign mdstall = MulDivE && (((mdState == IDLE) && MD_MULTI) ||
                                 ((mdState == BUSY) && (md_cnt != '0)));

    // Fixed priority: the deepest stalled stage decides which registers hold.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        FlushW = 1'b0;
        if (dstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (mdstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (lwstall || brstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (!imem_ready) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end else begin
            FlushD = PCSrcD || JumpD;
        end
    end

    // A dmem stall freezes the mul/div sequencer so a finished op is not retriggered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdState <= IDLE;
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else if (!dstall) begin
            case (mdState)
                IDLE: begin
                    if (MulDivE && MD_MULTI) begin
                        mdState <= BUSY;
                        md_cnt  <= MD_LOAD;
                        md_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (md_cnt != '0) begin
                        md_cnt <= md_cnt - MD_W'(1);
                    end else begin
                        mdState <= IDLE;
                        md_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (StallF && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Self-checking bench for mips_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_mips_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, JumpD, PCSrcD, MulDivE, MemAccessM, imem_ready, dmem_ready;

    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW;
    logic       ForwardAD, ForwardBD, md_busy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] stall_cnt;

    logic       StallF1, StallD1, StallE1, StallM1, FlushD1, FlushE1, FlushM1, FlushW1;
    logic       ForwardAD1, ForwardBD1, md_busy1;
    logic [1:0] ForwardAE1, ForwardBE1;
    logic [15:0] stall_cnt1;

    int errors = 0;
    int checks = 0;

    // Reference model state: cycles the current mul/div has spent in E, and stall counts.
    int age4 = 0;
    int cnt4 = 0;
    int cnt1 = 0;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] fl;
        logic [5:0] fw;
    } exp_t;

    logic [3:0] stalls, flushes, stalls1, flushes1;
    logic [5:0] fwd;
    assign stalls   = {StallF, StallD, StallE, StallM};
    assign flushes  = {FlushD, FlushE, FlushM, FlushW};
    assign fwd      = {ForwardAD, ForwardBD, ForwardAE, ForwardBE};
    assign stalls1  = {StallF1, StallD1, StallE1, StallM1};
    assign flushes1 = {FlushD1, FlushE1, FlushM1, FlushW1};

    mips_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .MulDivE(MulDivE),
        .MemAccessM(MemAccessM), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    mips_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD), .MulDivE(MulDivE),
        .MemAccessM(MemAccessM), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .StallM(StallM1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1), .FlushW(FlushW1),
        .ForwardAD(ForwardAD1), .ForwardBD(ForwardBD1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1),
        .md_busy(md_busy1), .stall_cnt(stall_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [4:0] src);
        if (RegWriteM && hit(WriteRegM, src)) return 2'b10;
        if (RegWriteW && hit(WriteRegW, src)) return 2'b01;
        return 2'b00;
    endfunction

    // Expected outputs from the hazard rules, given the model's mul/div age in E.
    function automatic exp_t model(input int lat, input int age);
        exp_t e;
        logic md, lw, br, dst;
        e = '0;
        dst = MemAccessM && !dmem_ready;
        md  = MulDivE && ((age > 0) ? (age < lat - 1) : (lat > 1));
        lw  = MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
        br  = BranchD && ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                          (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
        e.fw = {RegWriteM && hit(WriteRegM, RsD), RegWriteM && hit(WriteRegM, RtD),
                fwdSel(RsE), fwdSel(RtE)};
        if (dst) begin
            e.st = 4'b1111; e.fl = 4'b0001;
        end else if (md) begin
            e.st = 4'b1110; e.fl = 4'b0010;
        end else if (lw || br) begin
            e.st = 4'b1100; e.fl = 4'b0100;
        end else if (!imem_ready) begin
            e.st = 4'b1000; e.fl = 4'b1000;
        end else begin
            e.fl = {PCSrcD || JumpD, 3'b000};
        end
        return e;
    endfunction

    task automatic clear_inputs();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM} = '0;
        {BranchD, JumpD, PCSrcD, MulDivE, MemAccessM} = '0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
    endtask

    // Advance one clock; the model consumes this cycle's inputs.
    task automatic tick();
        exp_t e4, e1;
        @(negedge clk);
        e4 = model(4, age4);
        e1 = model(1, 0);
        if (!(MemAccessM && !dmem_ready)) begin
            if (age4 > 0) age4 = (age4 >= 3) ? 0 : age4 + 1;
            else if (MulDivE) age4 = 1;
        end
        if (e4.st[3]) cnt4 = (cnt4 < 15) ? cnt4 + 1 : 15;
        if (e1.st[3]) cnt1 = (cnt1 < 65535) ? cnt1 + 1 : 65535;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        age4 = 0; cnt4 = 0; cnt1 = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        #2;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy: got %0b expected 0", md_busy); end
        checks++;
        if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        do_reset();
        #1;
        checks++;
        if (stalls !== 4'b0000 || flushes !== 4'b0000) begin
            errors++; $display("FAIL reset_idle: got stalls=%b flushes=%b expected 0000/0000", stalls, flushes);
        end
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        RegWriteM = 1; WriteRegM = 5; RsE = 5; RsD = 5; RegWriteW = 1; WriteRegW = 5;
        #1;
        checks++;
        if (ForwardAE !== 2'b10 || ForwardAD !== 1'b1) begin
            errors++; $display("FAIL fwd_m_wins: got AE=%b AD=%b expected 10/1", ForwardAE, ForwardAD);
        end
        tick();
        WriteRegM = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01 || ForwardAD !== 1'b0) begin
            errors++; $display("FAIL fwd_w_only: got AE=%b AD=%b expected 01/0", ForwardAE, ForwardAD);
        end
        tick();
        RsE = 0; RtE = 5; RtD = 5; WriteRegM = 5; RegWriteW = 0;
        #1;
        checks++;
        if (ForwardBE !== 2'b10 || ForwardBD !== 1'b1 || ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_b: got BE=%b BD=%b AE=%b expected 10/1/00", ForwardBE, ForwardBD, ForwardAE);
        end
        tick();
        RegWriteM = 0; RegWriteW = 1; WriteRegW = 0; RtE = 0;
        #1;
        checks++;
        if (fwd !== 6'b000000) begin
            errors++; $display("FAIL fwd_reg0: got %b expected 000000", fwd);
        end
        tick();
    endtask

    task automatic test_lwstall();
        clear_inputs();
        MemtoRegE = 1; RtE = 2; RsD = 2;
        #1;
        checks++;
        if (stalls !== 4'b1100 || flushes !== 4'b0100) begin
            errors++; $display("FAIL lwstall: got stalls=%b flushes=%b expected 1100/0100", stalls, flushes);
        end
        tick();
        MemtoRegE = 0; RtE = 0; RsD = 0; RsE = 2; RegWriteW = 1; WriteRegW = 2;
        #1;
        checks++;
        if (ForwardAE !== 2'b01 || stalls !== 4'b0000) begin
            errors++; $display("FAIL lw_after: got AE=%b stalls=%b expected 01/0000", ForwardAE, stalls);
        end
        tick();
        clear_inputs();
        MemtoRegE = 1; RtE = 0; RsD = 0; RtD = 0;
        #1;
        checks++;
        if (stalls !== 4'b0000) begin
            errors++; $display("FAIL lw_reg0: got stalls=%b expected 0000", stalls);
        end
        tick();
    endtask

    task automatic test_muldiv();
        clear_inputs();
        MulDivE = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (StallE !== (c < 3) || FlushM !== (c < 3) || md_busy !== (c > 0)) begin
                errors++;
                $display("FAIL muldiv_c%0d: got StallE=%b FlushM=%b busy=%b expected %b/%b/%b",
                         c, StallE, FlushM, md_busy, c < 3, c < 3, c > 0);
            end
            tick();
        end
        MulDivE = 0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || stalls !== 4'b0000) begin
            errors++; $display("FAIL muldiv_done: got busy=%b stalls=%b expected 0/0000", md_busy, stalls);
        end
        tick();
    endtask

    task automatic test_muldiv_dmem();
        logic dlow;
        clear_inputs();
        MulDivE = 1; MemAccessM = 1;
        for (int c = 0; c < 7; c++) begin
            dlow = (c >= 1) && (c <= 3);
            dmem_ready = !dlow;
            #1;
            checks++;
            if (StallE !== (c < 6) || StallM !== dlow || FlushW !== dlow || FlushM !== (!dlow && c < 6)) begin
                errors++;
                $display("FAIL md_dmem_c%0d: got StallE=%b StallM=%b FlushW=%b FlushM=%b expected %b/%b/%b/%b",
                         c, StallE, StallM, FlushW, FlushM, c < 6, dlow, dlow, !dlow && c < 6);
            end
            tick();
        end
        clear_inputs();
        #1;
        checks++;
        if (md_busy !== 1'b0) begin errors++; $display("FAIL md_dmem_end: got busy=%b expected 0", md_busy); end
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 7; RtD = 7;
        #1;
        checks++;
        if (stalls !== 4'b1100 || flushes !== 4'b0100) begin
            errors++; $display("FAIL brstall_e: got stalls=%b flushes=%b expected 1100/0100", stalls, flushes);
        end
        tick();
        clear_inputs();
        BranchD = 1; MemtoRegM = 1; WriteRegM = 9; RsD = 9;
        #1;
        checks++;
        if (stalls !== 4'b1100) begin errors++; $display("FAIL brstall_m: got stalls=%b expected 1100", stalls); end
        tick();
        clear_inputs();
        PCSrcD = 1;
        #1;
        checks++;
        if (flushes !== 4'b1000 || StallF !== 1'b0) begin
            errors++; $display("FAIL taken: got flushes=%b StallF=%b expected 1000/0", flushes, StallF);
        end
        tick();
        PCSrcD = 0; JumpD = 1; imem_ready = 0;
        #1;
        checks++;
        if (stalls !== 4'b1000 || flushes !== 4'b1000) begin
            errors++; $display("FAIL imem_wait: got stalls=%b flushes=%b expected 1000/1000", stalls, flushes);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'(cnt4)) begin
            errors++; $display("FAIL branch_cnt: got %0d expected %0d", stall_cnt, cnt4);
        end
    endtask

    task automatic test_lat1();
        clear_inputs();
        MulDivE = 1;
        #1;
        checks++;
        if (stalls1 !== 4'b0000 || stalls !== 4'b1110) begin
            errors++; $display("FAIL lat1: got lat1 stalls=%b lat4 stalls=%b expected 0000/1110", stalls1, stalls);
        end
        tick();
        checks++;
        if (md_busy1 !== 1'b0) begin errors++; $display("FAIL lat1_busy: got %b expected 0", md_busy1); end
        clear_inputs();
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_saturate();
        do_reset();
        imem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (stall_cnt !== 4'((i + 1 < 15) ? i + 1 : 15) || stall_cnt1 !== 16'(i + 1)) begin
                errors++;
                $display("FAIL sat_%0d: got %0d/%0d expected %0d/%0d", i, stall_cnt, stall_cnt1,
                         (i + 1 < 15) ? i + 1 : 15, i + 1);
            end
        end
    endtask

    task automatic test_reset_busy();
        clear_inputs();
        MulDivE = 1;
        tick();
        tick();
        checks++;
        if (md_busy !== 1'b1) begin errors++; $display("FAIL rst_busy_pre: got %b expected 1", md_busy); end
        reset = 1'b1;
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_busy: got busy=%b cnt=%0d expected 0/0", md_busy, stall_cnt);
        end
        clear_inputs();
        age4 = 0; cnt4 = 0; cnt1 = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (stalls !== 4'b0000) begin errors++; $display("FAIL rst_no_stall: got %b expected 0000", stalls); end
        tick();
        checks++;
        if (md_busy !== 1'b0 || stall_cnt !== 4'd0) begin
            errors++; $display("FAIL rst_after: got busy=%b cnt=%0d expected 0/0", md_busy, stall_cnt);
        end
    endtask

    task automatic test_random();
        exp_t e4, e1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
            RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
            WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
            WriteRegW = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
            MemtoRegE = ($urandom_range(0, 3) == 0); MemtoRegM = ($urandom_range(0, 3) == 0);
            BranchD = ($urandom_range(0, 3) == 0); JumpD = ($urandom_range(0, 7) == 0);
            PCSrcD = ($urandom_range(0, 3) == 0); MulDivE = 1'($urandom);
            MemAccessM = 1'($urandom);
            imem_ready = ($urandom_range(0, 3) != 0); dmem_ready = ($urandom_range(0, 3) != 0);
            #1;
            e4 = model(4, age4);
            e1 = model(1, 0);
            checks++;
            if (stalls !== e4.st || flushes !== e4.fl || fwd !== e4.fw) begin
                errors++;
                $display("FAIL rnd_out_%0d: got st=%b fl=%b fw=%b expected st=%b fl=%b fw=%b",
                         n, stalls, flushes, fwd, e4.st, e4.fl, e4.fw);
            end
            checks++;
            if (md_busy !== (age4 > 0) || stall_cnt !== 4'(cnt4)) begin
                errors++;
                $display("FAIL rnd_state_%0d: got busy=%b cnt=%0d expected %b/%0d", n, md_busy, stall_cnt, age4 > 0, cnt4);
            end
            checks++;
            if (stalls1 !== e1.st || flushes1 !== e1.fl || md_busy1 !== 1'b0 || stall_cnt1 !== 16'(cnt1)) begin
                errors++;
                $display("FAIL rnd_lat1_%0d: got st=%b fl=%b busy=%b cnt=%0d expected %b/%b/0/%0d",
                         n, stalls1, flushes1, md_busy1, stall_cnt1, e1.st, e1.fl, cnt1);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_lwstall();
        test_muldiv();
        test_muldiv_dmem();
        test_branch();
        test_lat1();
        test_saturate();
        test_reset_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
